// File: rtl/mac_neuron.sv
// Streaming multiply-accumulate neuron: dot product of act/weight beats + bias, requantized to WIDTH bits.
// Latency: result valid 1 cycle after the accepted last beat.
// Backpressure: input stalls (in_ready=0) while a result waits; result holds until out_ready.
module mac_neuron #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_act,
  input  logic signed [WIDTH-1:0]     in_weight,
  input  logic                        in_last,
  input  logic signed [ACC_WIDTH-1:0] bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH-1:0]     out
);

  // Final sum carries two guard bits so acc + product + bias never wraps.
  localparam int SW = ACC_WIDTH + 2;
  // Half of one output LSB; zero when SHIFT is 0, which disables rounding.
  localparam logic signed [SW-1:0] ROUND   = SW'((2 ** SHIFT) / 2);
  localparam logic signed [SW-1:0] OUT_MAX = SW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

  state_t                      state, state_next;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [SW-1:0]        sum;
  logic signed [SW-1:0]        rounded;
  logic signed [SW-1:0]        shifted;
  logic signed [WIDTH-1:0]     sat;
  logic                        accept;

  // Full-precision product, final sum with bias, rounding, shift and saturation.
  always_comb begin
    prod    = in_act * in_weight;
    sum     = SW'(acc) + SW'(prod) + SW'(bias);
    rounded = sum + ROUND;
    shifted = rounded >>> SHIFT;
    if (shifted > OUT_MAX) begin
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shifted < OUT_MIN) begin
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat = shifted[WIDTH-1:0];
    end
  end

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; ACCUM takes beats, OUTPUT presents a result.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = !rst;
        if (in_valid && in_last) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Accumulator and result register; out only moves on a new result or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      out <= '0;
    end else if (accept) begin
      if (in_last) begin
        out <= sat;
        acc <= '0;
      end else begin
        acc <= acc + ACC_WIDTH'(prod);
      end
    end
  end

endmodule

// File: tb/tb_mac_neuron.sv
// Bench for mac_neuron: directed vectors, per-cycle comparison against a behavioural model.
// Latency: model predicts out_valid one cycle after the last accepted beat.
// Backpressure: exercises out_ready stalls with in_valid held high.
module tb_mac_neuron;

  localparam int W  = 8;
  localparam int AW = 32;
  localparam int SH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_act;
  logic signed [W-1:0]  in_weight;
  logic                 in_last;
  logic signed [AW-1:0] bias;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  out;

  int tests = 0;
  int fails = 0;
  longint cyc = 0;

  // model state
  bit                  check_en = 0;
  bit                  m_busy = 0;
  longint              m_acc = 0;
  logic signed [W-1:0] m_out = '0;
  logic [W-1:0]        mq[$];
  logic [W-1:0]        dq[$];
  longint              dcyc[$];

  mac_neuron #(.WIDTH(W), .ACC_WIDTH(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_weight(in_weight), .in_last(in_last), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint wrap_acc(input longint x);
    return (x <<< (64 - AW)) >>> (64 - AW);
  endfunction

  // Behavioural model: plain integer arithmetic on the beats seen at each edge.
  always @(posedge clk) begin
    longint p, s;
    cyc++;
    if (rst) begin
      m_busy = 0;
      m_acc  = 0;
      m_out  = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        p = longint'(in_act) * longint'(in_weight);
        if (in_last) begin
          s = m_acc + p + longint'(bias);
          s = (s + (longint'(1) <<< SH) / 2) >>> SH;
          if (s > (longint'(1) <<< (W - 1)) - 1)  s = (longint'(1) <<< (W - 1)) - 1;
          else if (s < -(longint'(1) <<< (W - 1))) s = -(longint'(1) <<< (W - 1));
          m_out  = s[W-1:0];
          m_busy = 1;
          m_acc  = 0;
        end else begin
          m_acc = wrap_acc(m_acc + p);
        end
      end
    end else if (out_ready) begin
      m_busy = 0;
      mq.push_back(m_out);
    end
    check_en = 1;
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy && !rst));
      chk("out_valid", 32'(out_valid), 32'(m_busy));
      chk("out", 32'(out), 32'(m_out));
      if (out_valid && out_ready) begin
        dq.push_back(out);
        dcyc.push_back(cyc);
      end
    end
  end

  task automatic beat(input int a, input int w, input bit last, input int b);
    bit ok;
    in_act    = W'(a);
    in_weight = W'(w);
    in_last   = last;
    bias      = AW'(b);
    in_valid  = 1'b1;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    out_ready = 1'b1;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: out_valid stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_res [8];
    exp_res = '{8'h03, 8'hF8, 8'h7F, 8'h80, 8'hFE, 8'h01, 8'h01, 8'hFF};
    rst = 1'b1; in_valid = 1'b0; in_act = '0; in_weight = '0;
    in_last = 1'b0; bias = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_out", 32'(out), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic dot product
    beat(3, 4, 0, 0);
    beat(5, 6, 1, 0);
    drain();
    // negative rounding
    beat(-8, 16, 1, 0);
    drain();
    // positive saturation
    repeat (3) beat(127, 127, 0, 0);
    beat(127, 127, 1, 0);
    drain();
    // negative saturation
    repeat (3) beat(-128, 127, 0, 0);
    beat(-128, 127, 1, 0);
    drain();
    // bias with backpressure; beats offered while stalled must be ignored
    beat(1, 1, 1, -40);
    in_act = 8'sd50; in_weight = 8'sd50; in_last = 1'b1; bias = 32'sd1000;
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0; in_last = 1'b0; bias = '0;
    drain();
    @(posedge clk); #1;
    // reset mid-vector
    beat(100, 100, 0, 0);
    beat(100, 100, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    beat(2, 8, 1, 0);
    drain();
    // back-to-back with out_ready tied high
    out_ready = 1'b1;
    beat(16, 1, 1, 0);
    beat(-16, 1, 1, 0);
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("dut_result_count", 32'(dq.size()), 32'd8);
    chk("model_result_count", 32'(mq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < dq.size()) chk($sformatf("dut_result_%0d", i), 32'(dq[i]), 32'(exp_res[i]));
      if (i < mq.size()) chk($sformatf("model_result_%0d", i), 32'(mq[i]), 32'(exp_res[i]));
    end
    if (dcyc.size() == 8) chk("b2b_spacing", 32'(dcyc[7] - dcyc[6]), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
